// File: rtl/cache_req_arbiter.sv
// Front-end request controller for the two-level cache. It grants two requesters round-robin,
// runs one lookup at a time, falls back to a backing-memory fetch with timeout, and keeps hit/miss stats.
module cache_req_arbiter #(
   parameter int                    ADDR_WIDTH     = 11,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    TIMEOUT_CYCLES = 64,
   parameter logic [DATA_WIDTH-1:0] ERR_DATA       = 32'hD00DFEED,
   parameter logic [15:0]           STAT_MAX       = 16'hFFFF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req0_valid,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   output logic                  req0_ready,
   input  logic                  req1_valid,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   output logic                  req1_ready,
   output logic                  rsp_valid,
   output logic                  rsp_id,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_level,
   output logic                  cache_read,
   output logic [ADDR_WIDTH-1:0] cache_addr,
   input  logic [DATA_WIDTH-1:0] cache_data,
   input  logic                  cache_l1_hit,
   input  logic                  cache_l2_hit,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   input  logic                  mem_valid,
   input  logic [DATA_WIDTH-1:0] mem_data,
   output logic [15:0]           stat_l1,
   output logic [15:0]           stat_l2,
   output logic [15:0]           stat_miss
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_CHECK,
      S_MEM_WAIT,
      S_RESP
   } state_t;

   // The wait counter holds values 0..TIMEOUT_CYCLES-1; the last value closes the window.
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

   localparam int STAT_L1   = 0;
   localparam int STAT_L2   = 1;
   localparam int STAT_MISS = 2;

   state_t                state_reg;
   state_t                state_next;

   logic [ADDR_WIDTH-1:0] addr_reg;
   logic                  id_reg;
   logic                  ptr_reg;
   logic [7:0]            cnt_reg;
   logic                  rsp_id_reg;
   logic [DATA_WIDTH-1:0] rsp_data_reg;
   logic [1:0]            rsp_level_reg;

   logic                  grant0;
   logic                  grant1;
   logic                  load_rsp;
   logic [DATA_WIDTH-1:0] rsp_data_next;
   logic [1:0]            rsp_level_next;
   logic                  cnt_clear;
   logic                  cnt_inc;
   logic [2:0]            stat_inc;
   logic [15:0]           stat_bus [3];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      grant0         = 1'b0;
      grant1         = 1'b0;
      cache_read     = 1'b0;
      mem_req        = 1'b0;
      rsp_valid      = 1'b0;
      load_rsp       = 1'b0;
      rsp_data_next  = '0;
      rsp_level_next = 2'd0;
      cnt_clear      = 1'b0;
      cnt_inc        = 1'b0;
      stat_inc       = 3'b000;
      case (state_reg)
         S_IDLE: begin
            // ptr_reg == 0 favours requester 0 when both are asking.
            if (req0_valid && (!req1_valid || !ptr_reg)) begin
               grant0 = 1'b1;
            end else if (req1_valid) begin
               grant1 = 1'b1;
            end
            if (grant0 || grant1) begin
               state_next = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            cache_read = 1'b1;
            state_next = S_CHECK;
         end
         S_CHECK: begin
            if (cache_l1_hit) begin
               load_rsp          = 1'b1;
               rsp_data_next     = cache_data;
               rsp_level_next    = 2'd0;
               stat_inc[STAT_L1] = 1'b1;
               state_next        = S_RESP;
            end else if (cache_l2_hit) begin
               load_rsp          = 1'b1;
               rsp_data_next     = cache_data;
               rsp_level_next    = 2'd1;
               stat_inc[STAT_L2] = 1'b1;
               state_next        = S_RESP;
            end else begin
               cnt_clear  = 1'b1;
               state_next = S_MEM_WAIT;
            end
         end
         S_MEM_WAIT: begin
            mem_req = 1'b1;
            // Data arriving in the final window cycle still counts as a fill.
            if (mem_valid) begin
               load_rsp            = 1'b1;
               rsp_data_next       = mem_data;
               rsp_level_next      = 2'd2;
               stat_inc[STAT_MISS] = 1'b1;
               state_next          = S_RESP;
            end else if (cnt_reg == TIMEOUT_LAST) begin
               load_rsp            = 1'b1;
               rsp_data_next       = ERR_DATA;
               rsp_level_next      = 2'd3;
               stat_inc[STAT_MISS] = 1'b1;
               state_next          = S_RESP;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         S_RESP: begin
            rsp_valid  = 1'b1;
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_reg      <= '0;
         id_reg        <= 1'b0;
         ptr_reg       <= 1'b0;
         cnt_reg       <= 8'd0;
         rsp_id_reg    <= 1'b0;
         rsp_data_reg  <= '0;
         rsp_level_reg <= 2'd0;
      end else begin
         if (grant0 || grant1) begin
            addr_reg <= grant1 ? req1_addr : req0_addr;
            id_reg   <= grant1;
            ptr_reg  <= ~grant1;
         end
         if (cnt_clear) begin
            cnt_reg <= 8'd0;
         end else if (cnt_inc) begin
            cnt_reg <= cnt_reg + 8'd1;
         end
         if (load_rsp) begin
            rsp_id_reg    <= id_reg;
            rsp_data_reg  <= rsp_data_next;
            rsp_level_reg <= rsp_level_next;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_stat
         logic [15:0] count_reg;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               count_reg <= 16'd0;
            end else if (stat_inc[gi] && (count_reg != STAT_MAX)) begin
               count_reg <= count_reg + 16'd1;
            end
         end

         assign stat_bus[gi] = count_reg;
      end
   endgenerate

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign cache_addr = addr_reg;
   assign mem_addr   = addr_reg;
   assign rsp_id     = rsp_id_reg;
   assign rsp_data   = rsp_data_reg;
   assign rsp_level  = rsp_level_reg;
   assign stat_l1    = stat_bus[STAT_L1];
   assign stat_l2    = stat_bus[STAT_L2];
   assign stat_miss  = stat_bus[STAT_MISS];

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: a vector table, hand-written reset/saturation sequences and
// random transactions, all checked against a transaction-level model of grants and responses.
module tb_cache_req_arbiter;

   localparam int          AW   = 11;
   localparam int          DW   = 32;
   localparam int          TMO  = 8;
   localparam logic [15:0] SMAX = 16'd50;
   localparam logic [31:0] ERR  = 32'hD00DFEED;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0_valid, req1_valid;
   logic [AW-1:0] req0_addr, req1_addr;
   logic          req0_ready, req1_ready;
   logic          rsp_valid, rsp_id;
   logic [DW-1:0] rsp_data;
   logic [1:0]    rsp_level;
   logic          cache_read;
   logic [AW-1:0] cache_addr;
   logic [DW-1:0] cache_data;
   logic          cache_l1_hit, cache_l2_hit;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_valid;
   logic [DW-1:0] mem_data;
   logic [15:0]   stat_l1, stat_l2, stat_miss;

   int checks   = 0;
   int failures = 0;
   int txn_no   = 0;

   // Transaction-level reference state
   bit          m_ptr;
   int unsigned m_stat [3];

   typedef struct {
      bit          v0;
      bit          v1;
      logic [10:0] a0;
      logic [10:0] a1;
      int          kind;   // 0 L1 hit, 1 L2 hit, 2 both hit, 3 miss
      int          d;      // MEM_WAIT cycles without mem_valid before it arrives
      logic [31:0] data;
      bit          exp_id;
      logic [1:0]  exp_level;
      logic [31:0] exp_data;
   } vec_t;

   vec_t tbl [10];

   cache_req_arbiter #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERR), .STAT_MAX(SMAX)
   ) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_level(rsp_level),
      .cache_read(cache_read), .cache_addr(cache_addr), .cache_data(cache_data),
      .cache_l1_hit(cache_l1_hit), .cache_l2_hit(cache_l2_hit),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_data(mem_data),
      .stat_l1(stat_l1), .stat_l2(stat_l2), .stat_miss(stat_miss)
   );

   always #5 clk = ~clk;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b (txn %0d)", name, act, exp, txn_no);
      end
   endtask

   task automatic chkv(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h (txn %0d)", name, act, exp, txn_no);
      end
   endtask

   task automatic model_reset();
      m_ptr = 1'b0;
      for (int i = 0; i < 3; i++) m_stat[i] = 0;
   endtask

   task automatic check_stats();
      chkv("stat_l1", 32'(stat_l1), m_stat[0]);
      chkv("stat_l2", 32'(stat_l2), m_stat[1]);
      chkv("stat_miss", 32'(stat_miss), m_stat[2]);
   endtask

   // Called just after a rising edge with the DUT in IDLE; returns just after the edge leaving RESP.
   task automatic run_txn(input bit v0, input bit v1, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                          input int kind, input int d, input logic [31:0] data,
                          input bit exp_id, input logic [1:0] exp_level, input logic [31:0] exp_data);
      logic [AW-1:0] addr;
      int            n_wait;
      int            si;
      addr   = exp_id ? a1 : a0;
      n_wait = (exp_level == 2'd3) ? TMO : d + 1;
      req0_valid = v0; req0_addr = a0;
      req1_valid = v1; req1_addr = a1;
      @(negedge clk);
      chk1("req0_ready", req0_ready, exp_id == 1'b0);
      chk1("req1_ready", req1_ready, exp_id == 1'b1);
      chk1("rsp_valid_idle", rsp_valid, 1'b0);
      chk1("mem_req_idle", mem_req, 1'b0);
      @(posedge clk); #1;
      if (exp_id) req1_valid = 1'b0; else req0_valid = 1'b0;
      cache_l1_hit = 1'($urandom); cache_l2_hit = 1'($urandom);
      cache_data = $urandom; mem_valid = 1'($urandom); mem_data = $urandom;
      @(negedge clk);
      chk1("cache_read_lookup", cache_read, 1'b1);
      chkv("cache_addr", 32'(cache_addr), 32'(addr));
      chk1("ready0_busy", req0_ready, 1'b0);
      chk1("ready1_busy", req1_ready, 1'b0);
      @(posedge clk); #1;
      cache_l1_hit = (kind == 0) || (kind == 2);
      cache_l2_hit = (kind == 1) || (kind == 2);
      cache_data   = (kind == 3) ? $urandom : data;
      mem_valid    = 1'($urandom);
      @(negedge clk);
      chk1("cache_read_check", cache_read, 1'b0);
      chk1("mem_req_check", mem_req, 1'b0);
      chk1("rsp_valid_check", rsp_valid, 1'b0);
      @(posedge clk); #1;
      if (kind == 3) begin
         for (int w = 1; w <= n_wait; w++) begin
            cache_l1_hit = 1'($urandom); cache_l2_hit = 1'($urandom);
            mem_valid = (w == d + 1);
            mem_data  = (w == d + 1) ? data : $urandom;
            @(negedge clk);
            chk1("mem_req_wait", mem_req, 1'b1);
            chkv("mem_addr", 32'(mem_addr), 32'(addr));
            chk1("rsp_valid_wait", rsp_valid, 1'b0);
            chk1("ready_wait", req0_ready | req1_ready, 1'b0);
            @(posedge clk); #1;
         end
      end
      // Stray strobes during RESP must be ignored.
      mem_valid = 1'b1; mem_data = $urandom; cache_l1_hit = 1'b1;
      si = (exp_level == 2'd0) ? 0 : (exp_level == 2'd1) ? 1 : 2;
      if (m_stat[si] < SMAX) m_stat[si]++;
      m_ptr = ~exp_id;
      @(negedge clk);
      chk1("rsp_valid", rsp_valid, 1'b1);
      chk1("rsp_id", rsp_id, exp_id);
      chkv("rsp_level", 32'(rsp_level), 32'(exp_level));
      chkv("rsp_data", rsp_data, exp_data);
      chk1("mem_req_resp", mem_req, 1'b0);
      check_stats();
      @(posedge clk); #1;
      mem_valid = 1'b0; cache_l1_hit = 1'b0; cache_l2_hit = 1'b0;
      $display("txn %0d id=%0d level=%0d data=%h stats=%0d/%0d/%0d",
               txn_no, rsp_id, rsp_level, rsp_data, stat_l1, stat_l2, stat_miss);
      txn_no++;
   endtask

   task automatic run_model_txn(input bit v0, input bit v1, input int kind, input int d);
      logic [AW-1:0] a0, a1;
      logic [31:0]   data;
      bit            eid;
      logic [1:0]    elvl;
      a0   = AW'($urandom);
      a1   = AW'($urandom);
      data = $urandom;
      eid  = (v0 && v1) ? m_ptr : v1;
      if (kind == 0 || kind == 2)  elvl = 2'd0;
      else if (kind == 1)          elvl = 2'd1;
      else if (d + 1 <= TMO)       elvl = 2'd2;
      else                         elvl = 2'd3;
      run_txn(v0, v1, a0, a1, kind, d, data, eid, elvl, (elvl == 2'd3) ? ERR : data);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b0, 11'h040, 11'h000, 0, 0,  32'h12345678, 1'b0, 2'd0, 32'h12345678};
      tbl[1] = '{1'b0, 1'b1, 11'h000, 11'h155, 2, 0,  32'hAAAA5555, 1'b1, 2'd0, 32'hAAAA5555};
      tbl[2] = '{1'b1, 1'b1, 11'h100, 11'h2A4, 1, 0,  32'h00000001, 1'b0, 2'd1, 32'h00000001};
      tbl[3] = '{1'b1, 1'b1, 11'h100, 11'h2A4, 1, 0,  32'h00000002, 1'b1, 2'd1, 32'h00000002};
      tbl[4] = '{1'b1, 1'b1, 11'h100, 11'h2A4, 1, 0,  32'h00000003, 1'b0, 2'd1, 32'h00000003};
      tbl[5] = '{1'b1, 1'b1, 11'h100, 11'h2A4, 1, 0,  32'h00000004, 1'b1, 2'd1, 32'h00000004};
      tbl[6] = '{1'b1, 1'b0, 11'h7FF, 11'h000, 3, 5,  32'hCAFEBABE, 1'b0, 2'd2, 32'hCAFEBABE};
      tbl[7] = '{1'b0, 1'b1, 11'h000, 11'h001, 3, 99, 32'h55555555, 1'b1, 2'd3, 32'hD00DFEED};
      tbl[8] = '{1'b1, 1'b0, 11'h3C3, 11'h000, 3, 7,  32'h0BADF00D, 1'b0, 2'd2, 32'h0BADF00D};
      tbl[9] = '{1'b0, 1'b1, 11'h000, 11'h456, 3, 0,  32'h11112222, 1'b1, 2'd2, 32'h11112222};

      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0; req0_addr = '0; req1_addr = '0;
      cache_data = '0; cache_l1_hit = 1'b0; cache_l2_hit = 1'b0;
      mem_valid = 1'b0; mem_data = '0;
      model_reset();
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk1("reset_ready", req0_ready | req1_ready, 1'b0);
      chk1("reset_rsp_valid", rsp_valid, 1'b0);
      chk1("reset_cache_read", cache_read, 1'b0);
      chk1("reset_mem_req", mem_req, 1'b0);
      chkv("reset_rsp_data", rsp_data, 32'h0);
      check_stats();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk1("idle_no_ready", req0_ready | req1_ready, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk1("idle_no_lookup", cache_read, 1'b0);
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         run_txn(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].a1, tbl[i].kind, tbl[i].d,
                 tbl[i].data, tbl[i].exp_id, tbl[i].exp_level, tbl[i].exp_data);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Reset in the middle of a memory fetch
      req0_valid = 1'b1; req0_addr = 11'h333;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk1("mem_req_before_rst", mem_req, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("rst_mem_req_drop", mem_req, 1'b0);
      chk1("rst_rsp_valid", rsp_valid, 1'b0);
      model_reset();
      check_stats();
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk1("post_rst_no_rsp", rsp_valid, 1'b0);
         chk1("post_rst_no_mem", mem_req, 1'b0);
      end
      @(posedge clk); #1;
      run_txn(1'b0, 1'b1, 11'h000, 11'h222, 0, 0, 32'h600DD00D, 1'b1, 2'd0, 32'h600DD00D);
      req0_valid = 1'b0; req1_valid = 1'b0;

      for (int i = 0; i < 40; i++) begin
         int unsigned vp;
         vp = $urandom_range(1, 3);
         run_model_txn(vp[0], vp[1], $urandom_range(0, 3), $urandom_range(0, 10));
      end
      req0_valid = 1'b0; req1_valid = 1'b0;

      // Drive L1 hits past the saturation limit
      for (int i = 0; i < int'(SMAX) + 5; i++) begin
         int unsigned vp;
         vp = $urandom_range(1, 3);
         run_model_txn(vp[0], vp[1], 0, 0);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      chkv("stat_l1_saturated", 32'(stat_l1), 32'(SMAX));
      chk1("final_rsp_valid", rsp_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
